// File: rtl/cpu_pkg.sv
// Shared definitions for cpu_core_param: opcodes, instruction field layout,
// ALU select and controller state encodings.
package cpu_pkg;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;
  localparam logic [7:0] OP_MUL   = 8'h08;

  localparam int FIELD_W  = 8;
  localparam int OPC_LSB  = 24;
  localparam int DST_LSB  = 16;
  localparam int SRC1_LSB = 8;
  localparam int SRC2_LSB = 0;

  typedef enum logic [1:0] {ALU_FWD, ALU_ADD, ALU_AND, ALU_OR} alu_sel_e;

  typedef enum logic {ST_IDLE, ST_MUL} state_e;

  function automatic logic [31:0] sext8(input logic [7:0] v);
    return {{24{v[7]}}, v};
  endfunction

endpackage

// File: rtl/cpu_core_param_seq_multiplier.sv
// Shift-add multiplier: one multiplier bit per cycle, DATA_W cycles per product.
// done_o and product_o are combinational so the caller can retire on the final edge.
module seq_multiplier #(
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] product_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d, acc_step;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;

  assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign busy_o    = busy_q;
  assign done_o    = busy_q && (cnt_q == CNT_W'(1));
  assign product_o = acc_step;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (busy_q) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) busy_d = 1'b0;
    end else if (start_i) begin
      mcand_d  = a_i;
      mplier_d = b_i;
      acc_d    = '0;
      cnt_d    = CNT_W'(DATA_W);
      busy_d   = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/cpu_core_param.sv
// Parametrised single-issue core: inline register file and ALU, j/beq control flow,
// fetch-valid handshake and a multi-cycle MUL that holds the PC while busy.
module cpu_core_param
  import cpu_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int REG_COUNT = 8,
  parameter int RIDX_W    = $clog2(REG_COUNT)
) (
  input  logic              CLK,
  input  logic              RESET,
  output logic [31:0]       PC,
  input  logic [31:0]       INSTRUCTION,
  input  logic              INSTR_VALID,
  output logic              BUSY,
  input  logic [RIDX_W-1:0] DBG_ADDR,
  output logic [DATA_W-1:0] DBG_DATA
);

  //  state   | meaning
  //  ST_IDLE | accepting instructions when INSTR_VALID is high
  //  ST_MUL  | multiplier iterating; fetch ignored, PC held
  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d, pc_plus4, br_target, imm_ext;
  logic [RIDX_W-1:0] mul_rd_q, mul_rd_d;
  logic [DATA_W-1:0] regs_q [REG_COUNT];

  logic [7:0]        opcode, dst_f, src1_f, src2_f;
  logic [RIDX_W-1:0] rd_idx, rs1_idx, rs2_idx;
  logic [DATA_W-1:0] rs1_val, rs2_val, imm, alu_b, alu_y;
  alu_sel_e          alu_sel;

  logic              rf_we;
  logic [RIDX_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              mul_start, mul_busy, mul_done;
  logic [DATA_W-1:0] mul_product;
  logic              unused_bits;

  assign opcode  = INSTRUCTION[OPC_LSB  +: FIELD_W];
  assign dst_f   = INSTRUCTION[DST_LSB  +: FIELD_W];
  assign src1_f  = INSTRUCTION[SRC1_LSB +: FIELD_W];
  assign src2_f  = INSTRUCTION[SRC2_LSB +: FIELD_W];
  assign rd_idx  = dst_f[RIDX_W-1:0];
  assign rs1_idx = src1_f[RIDX_W-1:0];
  assign rs2_idx = src2_f[RIDX_W-1:0];
  assign rs1_val = regs_q[rs1_idx];
  assign rs2_val = regs_q[rs2_idx];

  // Sign-extending to 32 then slicing also covers the truncating case for DATA_W < 8.
  assign imm_ext = sext8(src2_f);
  assign imm     = imm_ext[DATA_W-1:0];

  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = pc_plus4 + (sext8(dst_f) << 2);

  assign PC          = pc_q;
  assign DBG_DATA    = regs_q[DBG_ADDR];
  assign unused_bits = ^{src1_f, imm_ext, mul_busy};

  always_comb begin
    alu_sel = ALU_FWD;
    alu_b   = rs2_val;
    case (opcode)
      OP_LOADI: alu_b = imm;
      OP_ADD:   alu_sel = ALU_ADD;
      OP_SUB: begin
        alu_sel = ALU_ADD;
        alu_b   = ~rs2_val + DATA_W'(1);
      end
      OP_AND:   alu_sel = ALU_AND;
      OP_OR:    alu_sel = ALU_OR;
      default:  ;
    endcase
  end

  always_comb begin
    alu_y = alu_b;
    case (alu_sel)
      ALU_FWD: alu_y = alu_b;
      ALU_ADD: alu_y = rs1_val + alu_b;
      ALU_AND: alu_y = rs1_val & alu_b;
      ALU_OR:  alu_y = rs1_val | alu_b;
    endcase
  end

  seq_multiplier #(.DATA_W(DATA_W)) u_mul (
    .CLK       (CLK),
    .RESET     (RESET),
    .start_i   (mul_start),
    .a_i       (rs1_val),
    .b_i       (rs2_val),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      mul_rd_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      mul_rd_q <= mul_rd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (INSTR_VALID && (opcode == OP_MUL)) state_d = ST_MUL;
      ST_MUL:  if (mul_done) state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pc_d      = pc_q;
    mul_rd_d  = mul_rd_q;
    mul_start = 1'b0;
    rf_we     = 1'b0;
    rf_waddr  = rd_idx;
    rf_wdata  = alu_y;
    BUSY      = (state_q == ST_MUL);
    case (state_q)
      ST_IDLE: begin
        if (INSTR_VALID) begin
          case (opcode)
            OP_LOADI, OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR: begin
              rf_we = 1'b1;
              pc_d  = pc_plus4;
            end
            OP_J:   pc_d = br_target;
            OP_BEQ: pc_d = (rs1_val == rs2_val) ? br_target : pc_plus4;
            OP_MUL: begin
              mul_start = 1'b1;
              mul_rd_d  = rd_idx;
            end
            default: pc_d = pc_plus4;
          endcase
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          rf_we    = 1'b1;
          rf_waddr = mul_rd_q;
          rf_wdata = mul_product;
          pc_d     = pc_plus4;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else if (rf_we) begin
      regs_q[rf_waddr] <= rf_wdata;
    end
  end

endmodule

// File: tb/tb_cpu_core_param.sv
// Bench for cpu_core_param: an 8-bit/8-reg and a 16-bit/16-reg instance, each
// compared against an instruction-level reference model after every instruction.
`timescale 1ns/1ps
module tb_cpu_core_param;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] instr8, instr16, pc8, pc16;
  logic        valid8, valid16, busy8, busy16;
  logic [2:0]  dbga8;
  logic [7:0]  dbgd8;
  logic [3:0]  dbga16;
  logic [15:0] dbgd16;

  int total = 0;
  int bad   = 0;

  logic [31:0] mpc [2];
  logic [31:0] mreg [2][16];
  int          mw [2];
  int          mn [2];

  always #50 CLK = ~CLK;

  cpu_core_param #(.DATA_W(8), .REG_COUNT(8)) u_dut8 (
    .CLK(CLK), .RESET(RESET), .PC(pc8), .INSTRUCTION(instr8), .INSTR_VALID(valid8),
    .BUSY(busy8), .DBG_ADDR(dbga8), .DBG_DATA(dbgd8)
  );

  cpu_core_param #(.DATA_W(16), .REG_COUNT(16)) u_dut16 (
    .CLK(CLK), .RESET(RESET), .PC(pc16), .INSTRUCTION(instr16), .INSTR_VALID(valid16),
    .BUSY(busy16), .DBG_ADDR(dbga16), .DBG_DATA(dbgd16)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] sx8(input logic [7:0] v);
    return {{24{v[7]}}, v};
  endfunction

  function automatic logic [31:0] msk(input int d);
    return (mw[d] >= 32) ? 32'hFFFF_FFFF : ((32'd1 << mw[d]) - 32'd1);
  endfunction

  function automatic logic [31:0] mk(input logic [7:0] op, input logic [7:0] f1,
                                     input logic [7:0] f2, input logic [7:0] f3);
    return {op, f1, f2, f3};
  endfunction

  function automatic logic [31:0] dut_pc(input int d);
    return (d == 0) ? pc8 : pc16;
  endfunction

  function automatic logic [31:0] dut_busy(input int d);
    return {31'd0, (d == 0) ? busy8 : busy16};
  endfunction

  task automatic drive(input int d, input logic [31:0] ins, input logic v);
    if (d == 0) begin instr8 = ins; valid8 = v; end
    else begin instr16 = ins; valid16 = v; end
  endtask

  task automatic read_reg(input int d, input int i, output logic [31:0] v);
    if (d == 0) begin dbga8 = 3'(i); #1; v = {24'd0, dbgd8}; end
    else begin dbga16 = 4'(i); #1; v = {16'd0, dbgd16}; end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mpc[d] = 32'd0;
      for (int i = 0; i < 16; i++) mreg[d][i] = 32'd0;
    end
  endtask

  task automatic check_state(input int d, input string tag);
    logic [31:0] v;
    check_val($sformatf("%s d%0d pc", tag, d), dut_pc(d), mpc[d]);
    check_val($sformatf("%s d%0d busy", tag, d), dut_busy(d), 32'd0);
    for (int i = 0; i < mn[d]; i++) begin
      read_reg(d, i, v);
      check_val($sformatf("%s d%0d r%0d", tag, d, i), v, mreg[d][i]);
    end
  endtask

  task automatic expect_reg(input int d, input int i, input logic [31:0] exp, input string tag);
    logic [31:0] v;
    read_reg(d, i, v);
    check_val(tag, v, exp);
  endtask

  // Runs one instruction on DUT d, advances the model, then checks the whole state.
  task automatic exec(input int d, input logic [31:0] ins, input logic v, input string tag);
    logic [7:0]  op;
    int          rd, rs1, rs2, cnt;
    logic [31:0] a, b, m, res;
    bit          wr;
    op  = ins[31:24];
    rd  = int'(ins[23:16]) % mn[d];
    rs1 = int'(ins[15:8]) % mn[d];
    rs2 = int'(ins[7:0]) % mn[d];
    m   = msk(d);
    a   = mreg[d][rs1];
    b   = mreg[d][rs2];
    wr  = 1'b0;
    res = 32'd0;
    drive(d, ins, v);
    @(posedge CLK); #1;
    if (v) begin
      if (op == 8'h08) begin
        check_val({tag, " mul pc hold"}, dut_pc(d), mpc[d]);
        cnt = 0;
        while (dut_busy(d) == 32'd1 && cnt < 100) begin
          drive(d, $urandom, 1'b1);
          cnt++;
          @(posedge CLK); #1;
        end
        check_val({tag, " mul busy cycles"}, 32'(cnt), 32'(mw[d]));
        res = (a * b) & m;
        wr  = 1'b1;
        mpc[d] = mpc[d] + 32'd4;
      end else begin
        case (op)
          8'h00: begin res = sx8(ins[7:0]) & m; wr = 1'b1; end
          8'h01: begin res = b; wr = 1'b1; end
          8'h02: begin res = (a + b) & m; wr = 1'b1; end
          8'h03: begin res = (a - b) & m; wr = 1'b1; end
          8'h04: begin res = a & b; wr = 1'b1; end
          8'h05: begin res = a | b; wr = 1'b1; end
          default: ;
        endcase
        if (op == 8'h06 || (op == 8'h07 && a == b))
          mpc[d] = mpc[d] + 32'd4 + (sx8(ins[23:16]) << 2);
        else
          mpc[d] = mpc[d] + 32'd4;
      end
    end
    drive(d, 32'd0, 1'b0);
    if (wr) mreg[d][rd] = res;
    check_state(d, tag);
  endtask

  // Asserts reset away from the clock edge; PC must clear without waiting for a clock.
  task automatic pulse_reset(input string tag);
    #30;
    RESET = 1'b1;
    #1;
    check_val({tag, " pc8 async"}, pc8, 32'd0);
    check_val({tag, " pc16 async"}, pc16, 32'd0);
    model_reset();
    check_state(0, tag);
    check_state(1, tag);
    #5;
    RESET = 1'b0;
  endtask

  initial begin
    logic [7:0]  op;
    logic [31:0] ins;
    mw[0] = 8;  mn[0] = 8;
    mw[1] = 16; mn[1] = 16;
    model_reset();
    RESET = 1'b1;
    drive(0, 32'd0, 1'b0);
    drive(1, 32'd0, 1'b0);
    dbga8 = '0;
    dbga16 = '0;
    #120;
    RESET = 1'b0;
    check_state(0, "por");
    check_state(1, "por");

    // dirty some state, then reset mid-cycle
    exec(0, mk(8'h00, 8'd1, 8'd0, 8'h55), 1'b1, "pre ld");
    exec(1, mk(8'h00, 8'd3, 8'd0, 8'h9A), 1'b1, "pre ld16");
    pulse_reset("rst1");

    exec(0, mk(8'h00, 8'd1, 8'd0, 8'h05), 1'b1, "ld r1");
    check_val("pc after ld r1", pc8, 32'h04);
    exec(0, mk(8'h00, 8'd2, 8'd0, 8'h03), 1'b1, "ld r2");
    check_val("pc after ld r2", pc8, 32'h08);
    exec(0, mk(8'h03, 8'd3, 8'd1, 8'd2), 1'b1, "sub");
    check_val("pc after sub", pc8, 32'h0C);
    expect_reg(0, 3, 32'h02, "sub r3");

    exec(0, mk(8'h00, 8'd1, 8'd0, 8'hFF), 1'b1, "ld ff");
    exec(0, mk(8'h00, 8'd2, 8'd0, 8'h01), 1'b1, "ld 01");
    exec(0, mk(8'h02, 8'd4, 8'd1, 8'd2), 1'b1, "add wrap");
    expect_reg(0, 4, 32'h00, "add wrap r4");
    exec(0, mk(8'h00, 8'd5, 8'd0, 8'h80), 1'b1, "ld 80");
    expect_reg(0, 5, 32'h80, "ld 80 r5");

    exec(0, mk(8'h00, 8'd2, 8'd0, 8'hFF), 1'b1, "ld r2 eq");
    exec(0, mk(8'h06, 8'hFB, 8'd0, 8'd0), 1'b1, "j to 10");
    check_val("j to 10 pc", pc8, 32'h10);
    exec(0, mk(8'h07, 8'hFE, 8'd1, 8'd2), 1'b1, "beq taken");
    check_val("beq taken pc", pc8, 32'h0C);
    exec(0, mk(8'h00, 8'd2, 8'd0, 8'h01), 1'b1, "ld r2 ne");
    exec(0, mk(8'h07, 8'hFE, 8'd1, 8'd2), 1'b1, "beq not taken");
    check_val("beq not taken pc", pc8, 32'h14);
    exec(0, mk(8'h06, 8'h02, 8'd0, 8'd0), 1'b1, "j to 20");
    exec(0, mk(8'h06, 8'h03, 8'd0, 8'd0), 1'b1, "j off 3");
    check_val("j off 3 pc", pc8, 32'h30);

    exec(0, mk(8'h00, 8'd1, 8'd0, 8'h0D), 1'b1, "ld 0d");
    exec(0, mk(8'h00, 8'd2, 8'd0, 8'h0B), 1'b1, "ld 0b");
    exec(0, mk(8'h06, 8'hF3, 8'd0, 8'd0), 1'b1, "j to 08");
    check_val("j to 08 pc", pc8, 32'h08);
    exec(0, mk(8'h08, 8'd4, 8'd1, 8'd2), 1'b1, "mul 0dx0b");
    check_val("mul retire pc", pc8, 32'h0C);
    expect_reg(0, 4, 32'h8F, "mul r4");
    exec(0, mk(8'h00, 8'd1, 8'd0, 8'h20), 1'b1, "ld 20");
    exec(0, mk(8'h00, 8'd2, 8'd0, 8'h10), 1'b1, "ld 10");
    exec(0, mk(8'h08, 8'd5, 8'd1, 8'd2), 1'b1, "mul 20x10");
    expect_reg(0, 5, 32'h00, "mul r5 wrap");

    for (int k = 0; k < 3; k++) exec(0, mk(8'h02, 8'd6, 8'd1, 8'd2), 1'b0, "invalid add");
    exec(0, mk(8'h3F, 8'd1, 8'd1, 8'd2), 1'b1, "unknown op");

    // reset partway through a MUL: no write may land
    exec(0, mk(8'h00, 8'd1, 8'd0, 8'h0D), 1'b1, "ld6 0d");
    exec(0, mk(8'h00, 8'd2, 8'd0, 8'h0B), 1'b1, "ld6 0b");
    drive(0, mk(8'h08, 8'd6, 8'd1, 8'd2), 1'b1);
    @(posedge CLK); #1;
    drive(0, 32'd0, 1'b0);
    repeat (3) @(posedge CLK);
    #1;
    check_val("mul busy before rst", {31'd0, busy8}, 32'd1);
    pulse_reset("rst mul");
    for (int k = 0; k < 10; k++) exec(0, 32'd0, 1'b0, "post rst idle");
    expect_reg(0, 6, 32'h00, "aborted mul r6");

    exec(1, mk(8'h00, 8'd1, 8'd0, 8'h0D), 1'b1, "w16 ld 0d");
    exec(1, mk(8'h00, 8'd2, 8'd0, 8'h0B), 1'b1, "w16 ld 0b");
    exec(1, mk(8'h08, 8'd4, 8'd1, 8'd2), 1'b1, "w16 mul");
    expect_reg(1, 4, 32'h008F, "w16 mul r4");
    exec(1, mk(8'h00, 8'd1, 8'd0, 8'h80), 1'b1, "w16 ld 80");
    exec(1, mk(8'h08, 8'd5, 8'd1, 8'd1), 1'b1, "w16 mul sq");

    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 120; k++) begin
        op = 8'($urandom_range(0, 9));
        if (op == 8'd9) op = 8'($urandom_range(9, 255));
        ins = {op, 8'($urandom), 8'($urandom), 8'($urandom)};
        exec(d, ins, ($urandom_range(0, 4) != 0), $sformatf("rnd%0d", k));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
